// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetches over a
// valid/ready request channel, collects in-order responses into a small
// {pc, instr} FIFO and hands them to decode. Redirects from execute flush
// the FIFO and discard any responses still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [31:0]   Nop      = 32'h0000_0013;
    localparam logic [31:0]   ResetPc  = {RESET_PC[31:2], 2'b00};
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW:0]   DepthCrd = (CntW + 1)'(DEPTH);

    // Architectural state
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;

    // FIFO storage, no reset needed: count_q gates every read
    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];

    logic [CntW:0] credit_used;
    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic [31:0]   redirect_target;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[31:2], 2'b00};

    // Credit: in-flight requests plus buffered entries never exceed DEPTH,
    // which is what guarantees a response always finds a free FIFO slot.
    assign credit_used   = {1'b0, outst_q} + {1'b0, count_q};
    assign fifo_nonempty = (count_q != '0);

    // Request channel and handshake qualifiers
    always_comb begin
        imem_req_valid = !rst && !redirect_valid && (credit_used < DepthCrd);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error; ignore it.
        resp_fire      = imem_resp_valid && (outst_q != '0);
        push           = resp_fire && !redirect_valid && (drop_q == '0);
        pop            = fifo_nonempty && out_ready && !redirect_valid;
    end

    // Decode-facing outputs: FIFO head, or NOP at resp_pc when empty
    always_comb begin
        out_valid = 1'b0;
        out_instr = Nop;
        out_pc    = 32'h0000_0000;
        if (!rst) begin
            out_valid = fifo_nonempty;
            if (fifo_nonempty) begin
                out_instr = fifo_instr_q[rd_ptr_q];
                out_pc    = fifo_pc_q[rd_ptr_q];
            end else begin
                out_pc = resp_pc_q;
            end
        end
    end

    // Next-state logic; redirect overrides every other update
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CntW'(req_fire) - CntW'(resp_fire);

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight is stale; a response arriving now
            // is already discarded, so it does not need a drop slot.
            drop_d     = outst_q - CntW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_fire && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= ResetPc;
            resp_pc_q  <= ResetPc;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_resp_data;
        end
    end

`ifndef SYNTHESIS
    // Overflow here would mean the credit check let too many requests out.
    assert property (@(posedge clk) disable iff (rst) push |-> (count_q != DepthCnt));
    assert property (@(posedge clk) disable iff (rst) imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable in-order memory
// model, and a scoreboard queue popped by a monitor on each decode handshake.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    bit sb_on  = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    // Memory contents: each word is its address XOR a fixed pattern
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = memf(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // In-order memory: samples acceptance just before the edge, drives the
    // response for the new cycle just after it.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        int          cyc;
        pend_t       p;
        cyc             = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (imem_resp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
            if (acc) begin
                p.addr = acc_addr;
                p.due  = cyc + lat - 1;
                pend_q.push_back(p);
            end
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(pend_q[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    // Scoreboard monitor: one pop per accepted decode handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && sb_on && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got pc %h instr %h, required no instruction",
                             out_pc, out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit found;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset values, then streaming from RESET_PC with 1-cycle memory
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 32'h0);
        push_exp(32'h0, 12);
        tick();
        rst = 1'b0;
        n   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_req_valid", 32'(imem_req_valid), 32'd1);
                chk("first_req_addr", imem_req_addr, 32'h0);
            end
            if (out_valid) break;
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'd2);
        drain("t1_drain");
        out_ready = 1'b0;

        // Decode stall: FIFO fills, requests stop, order resumes intact
        push_exp(32'h30, 10);
        repeat (10) tick();
        @(negedge clk);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_head_pc", out_pc, 32'h30);
        tick();
        out_ready = 1'b1;
        drain("t2_drain");
        out_ready = 1'b0;

        // Redirect with two requests outstanding on 3-cycle memory
        lat = 3;
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        found          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!imem_req_valid && !out_valid && !imem_resp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_two_outstanding", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        push_exp(32'h100, 4);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        drain("t3_drain");
        out_ready = 1'b0;

        // Redirect coinciding with a response and a pop
        lat       = 1;
        sb_on     = 1'b0;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid && imem_resp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_resp_and_pop", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
        sb_on          = 1'b1;
        push_exp(32'h400, 4);
        @(negedge clk);
        chk("t4_fifo_empty", 32'(out_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h400);
        drain("t4_drain");
        out_ready = 1'b0;

        // Misaligned target, back-to-back redirects, PC wrap at 2^32
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("t5_aligned_addr", imem_req_addr, 32'h100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_last_wins_addr", imem_req_addr, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC, 4);
        tick();
        out_ready = 1'b1;
        drain("t5_drain");
        out_ready = 1'b0;

        // Asynchronous reset mid-fetch with one request outstanding
        lat = 3;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        tick();
        redirect_valid = 1'b0;
        found          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_head_seen", 32'(found), 32'd1);
        chk("t6_one_outstanding", 32'(imem_req_valid), 32'd0);
        chk("t6_head_pc", out_pc, 32'h500);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_instr", out_instr, 32'h0000_0013);
        chk("t6_rst_out_pc", out_pc, 32'h0);
        lat       = 1;
        out_ready = 1'b1;
        push_exp(32'h0, 4);
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
